titan_hazard_ctrl: RTL and testbench

//  Pipeline hazard controller; drives the stall/flush inputs of IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/titan_hazard_pkg.sv | 21 ++
 rtl/titan_fwd_unit.sv | 33 +++
 rtl/titan_hazard_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_titan_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/titan_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hz_state_t : controller FSM state encoding
//   FWD_*      : EX operand forwarding select encodings
//   reg_match  : register-number compare that never matches x0
package titan_hazard_pkg;

  typedef enum logic {
    ST_RUN        = 1'b0,
    ST_TRAP_DRAIN = 1'b1
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // x0 is hardwired to zero, so a write to it is never a real producer.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 5'd0);
  endfunction

endpackage

// File: rtl/titan_fwd_unit.sv
// EX operand forwarding select for one source operand (purely combinational).
// Ports:
//   i_rs          source register read by the ID instruction
//   i_ex_we       EX instruction writes a register
//   i_ex_waddr    EX destination register
//   i_ex_mem_read EX instruction is a load (result not yet available)
//   i_mem_we      MEM instruction writes a register
//   i_mem_waddr   MEM destination register
//   o_sel         FWD_RF / FWD_EX / FWD_MEM
module titan_fwd_unit
  import titan_hazard_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic       i_ex_we,
  input  logic [4:0] i_ex_waddr,
  input  logic       i_ex_mem_read,
  input  logic       i_mem_we,
  input  logic [4:0] i_mem_waddr,
  output logic [1:0] o_sel
);

  // The younger producer (EX) wins; a load in EX has no data yet, so the
  // compare falls through to MEM (load-use stall covers the real hazard).
  always_comb begin
    o_sel = FWD_RF;
    if (i_ex_we && !i_ex_mem_read && reg_match(i_ex_waddr, i_rs)) begin
      o_sel = FWD_EX;
    end else if (i_mem_we && reg_match(i_mem_waddr, i_rs)) begin
      o_sel = FWD_MEM;
    end
  end

endmodule

// File: rtl/titan_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush control for the IF/ID, ID/EX,
// EX/MEM and MEM/WB registers, EX operand forwarding selects, trap redirect
// pulse and bus-stall timeout pulse.
//
//   state         | meaning
//   --------------+---------------------------------------------------------
//   ST_RUN        | normal operation, hazard priority rules applied
//   ST_TRAP_DRAIN | one cycle after a MEM trap: drain ID/EX/MEM, trap_take=1
//
// Ports:
//   i_clk, i_rst_n                  clock (rising edge), async active-low reset
//   i_id_rs1/2, i_id_use_rs1/2      ID source registers and whether they are read
//   i_ex_waddr/we/mem_read          EX destination, write enable, load flag
//   i_mem_waddr/we                  MEM destination, write enable
//   i_if_busy, i_mem_busy           instruction / data bus not ready
//   i_ex_branch_taken               taken branch/jump resolved in EX
//   i_mem_exception                 MEM-stage instruction traps
//   o_pc_stall, o_*_stall           hold enables (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
//   o_*_flush                       bubble insert (IF/ID, ID/EX, EX/MEM, MEM/WB)
//   o_fwd_a_sel, o_fwd_b_sel        EX operand source select
//   o_trap_take                     registered pulse: redirect to trap vector
//   o_bus_timeout                   registered pulse: bus stalled STALL_TIMEOUT cycles
module titan_hazard_ctrl
  import titan_hazard_pkg::*;
#(
  parameter int STALL_TIMEOUT = 255,
  parameter int CNT_W         = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic [4:0] i_ex_waddr,
  input  logic       i_ex_we,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_mem_waddr,
  input  logic       i_mem_we,
  input  logic       i_if_busy,
  input  logic       i_mem_busy,
  input  logic       i_ex_branch_taken,
  input  logic       i_mem_exception,
  output logic       o_if_stall,
  output logic       o_id_stall,
  output logic       o_ex_stall,
  output logic       o_mem_stall,
  output logic       o_id_flush,
  output logic       o_ex_flush,
  output logic       o_mem_flush,
  output logic       o_wb_flush,
  output logic       o_pc_stall,
  output logic [1:0] o_fwd_a_sel,
  output logic [1:0] o_fwd_b_sel,
  output logic       o_trap_take,
  output logic       o_bus_timeout
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(STALL_TIMEOUT);
  localparam logic [CNT_W-1:0] TO_PRE = CNT_W'(STALL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  hz_state_t        r_state;
  hz_state_t        w_state_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_trap_take;
  logic             r_bus_timeout;
  logic             w_load_use;
  logic             w_bus_busy;

  assign w_bus_busy = i_if_busy | i_mem_busy;

  assign w_load_use = i_ex_mem_read && i_ex_we &&
                      ((i_id_use_rs1 && reg_match(i_ex_waddr, i_id_rs1)) ||
                       (i_id_use_rs2 && reg_match(i_ex_waddr, i_id_rs2)));

  titan_fwd_unit u_fwd_a (
    .i_rs          (i_id_rs1),
    .i_ex_we       (i_ex_we),
    .i_ex_waddr    (i_ex_waddr),
    .i_ex_mem_read (i_ex_mem_read),
    .i_mem_we      (i_mem_we),
    .i_mem_waddr   (i_mem_waddr),
    .o_sel         (o_fwd_a_sel)
  );

  titan_fwd_unit u_fwd_b (
    .i_rs          (i_id_rs2),
    .i_ex_we       (i_ex_we),
    .i_ex_waddr    (i_ex_waddr),
    .i_ex_mem_read (i_ex_mem_read),
    .i_mem_we      (i_mem_we),
    .i_mem_waddr   (i_mem_waddr),
    .o_sel         (o_fwd_b_sel)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Stall/flush decode. While reset is asserted every pipeline register is
  // flushed so nothing half-formed leaks out when reset releases.
  always_comb begin
    w_state_next = r_state;
    o_pc_stall   = 1'b0;
    o_if_stall   = 1'b0;
    o_id_stall   = 1'b0;
    o_ex_stall   = 1'b0;
    o_mem_stall  = 1'b0;
    o_id_flush   = 1'b0;
    o_ex_flush   = 1'b0;
    o_mem_flush  = 1'b0;
    o_wb_flush   = 1'b0;

    if (!i_rst_n) begin
      w_state_next = ST_RUN;
      o_id_flush   = 1'b1;
      o_ex_flush   = 1'b1;
      o_mem_flush  = 1'b1;
      o_wb_flush   = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_mem_exception) begin
            // Trap beats mem_busy: the trapping access is abandoned.
            w_state_next = ST_TRAP_DRAIN;
            o_id_flush   = 1'b1;
            o_ex_flush   = 1'b1;
            o_mem_flush  = 1'b1;
            o_wb_flush   = 1'b1;
          end else if (i_mem_busy) begin
            o_pc_stall  = 1'b1;
            o_if_stall  = 1'b1;
            o_id_stall  = 1'b1;
            o_ex_stall  = 1'b1;
            o_mem_stall = 1'b1;
            o_wb_flush  = 1'b1;
          end else if (w_load_use) begin
            // Hold the consumer in ID, bubble into EX; one cycle later the
            // load is in MEM and forwarding takes over.
            o_pc_stall = 1'b1;
            o_if_stall = 1'b1;
            o_ex_flush = 1'b1;
          end else if (i_ex_branch_taken) begin
            o_id_flush = 1'b1;
            o_ex_flush = 1'b1;
          end else if (i_if_busy) begin
            o_pc_stall = 1'b1;
            o_id_flush = 1'b1;
          end
        end
        ST_TRAP_DRAIN: begin
          // Exceptions and mem_busy are ignored here; always one cycle.
          w_state_next = ST_RUN;
          o_id_flush   = 1'b1;
          o_ex_flush   = 1'b1;
          o_mem_flush  = 1'b1;
        end
        default: begin
          w_state_next = ST_RUN;
        end
      endcase
    end
  end

  // trap_take mirrors entry into TRAP_DRAIN. The stall counter saturates so
  // a long stall yields exactly one timeout pulse; the trap redirect restarts it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_trap_take   <= 1'b0;
      r_bus_timeout <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      r_trap_take <= (w_state_next == ST_TRAP_DRAIN);
      if (r_trap_take) begin
        r_stall_cnt   <= '0;
        r_bus_timeout <= 1'b0;
      end else if (w_bus_busy) begin
        if (r_stall_cnt != TO_CNT) begin
          r_stall_cnt <= r_stall_cnt + ONE;
        end
        r_bus_timeout <= (r_stall_cnt == TO_PRE);
      end else begin
        r_stall_cnt   <= '0;
        r_bus_timeout <= 1'b0;
      end
    end
  end

  assign o_trap_take   = r_trap_take;
  assign o_bus_timeout = r_bus_timeout;

endmodule

// File: tb/tb_titan_hazard_ctrl.sv
module tb_titan_hazard_ctrl;

  localparam int TO = 4;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_waddr, mem_waddr;
  logic       id_use_rs1, id_use_rs2, ex_we, ex_mem_read, mem_we;
  logic       if_busy, mem_busy, ex_branch_taken, mem_exception;
  logic       if_stall, id_stall, ex_stall, mem_stall;
  logic       id_flush, ex_flush, mem_flush, wb_flush, pc_stall;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       trap_take, bus_timeout;

  titan_hazard_ctrl #(.STALL_TIMEOUT(TO), .CNT_W(8)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_id_rs1          (id_rs1),
    .i_id_rs2          (id_rs2),
    .i_id_use_rs1      (id_use_rs1),
    .i_id_use_rs2      (id_use_rs2),
    .i_ex_waddr        (ex_waddr),
    .i_ex_we           (ex_we),
    .i_ex_mem_read     (ex_mem_read),
    .i_mem_waddr       (mem_waddr),
    .i_mem_we          (mem_we),
    .i_if_busy         (if_busy),
    .i_mem_busy        (mem_busy),
    .i_ex_branch_taken (ex_branch_taken),
    .i_mem_exception   (mem_exception),
    .o_if_stall        (if_stall),
    .o_id_stall        (id_stall),
    .o_ex_stall        (ex_stall),
    .o_mem_stall       (mem_stall),
    .o_id_flush        (id_flush),
    .o_ex_flush        (ex_flush),
    .o_mem_flush       (mem_flush),
    .o_wb_flush        (wb_flush),
    .o_pc_stall        (pc_stall),
    .o_fwd_a_sel       (fwd_a_sel),
    .o_fwd_b_sel       (fwd_b_sel),
    .o_trap_take       (trap_take),
    .o_bus_timeout     (bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector: {pc,if,id,ex,mem stall | id,ex,mem,wb flush | fwd_a | fwd_b | trap_take | bus_timeout}
  localparam logic [4:0] S0   = 5'b00000;
  localparam logic [4:0] S_MB = 5'b11111;
  localparam logic [4:0] S_LU = 5'b11000;
  localparam logic [4:0] S_PC = 5'b10000;
  localparam logic [3:0] F0    = 4'b0000;
  localparam logic [3:0] F_ALL = 4'b1111;
  localparam logic [3:0] F_DR  = 4'b1110;
  localparam logic [3:0] F_BR  = 4'b1100;
  localparam logic [3:0] F_LU  = 4'b0100;
  localparam logic [3:0] F_ID  = 4'b1000;
  localparam logic [3:0] F_WB  = 4'b0001;
  localparam logic [1:0] RF = 2'b00, EX = 2'b01, MEM = 2'b10;

  typedef struct {
    string       name;
    logic [14:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  function automatic logic [14:0] mk(input logic [4:0] s, input logic [3:0] f,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic tt, input logic to);
    return {s, f, fa, fb, tt, to};
  endfunction

  // Monitor: the DUT presents a full output vector every cycle; compare it
  // mid-cycle whenever the stimulus side has queued an expectation.
  always @(negedge clk) begin
    sb_t         e;
    logic [14:0] got;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = {pc_stall, if_stall, id_stall, ex_stall, mem_stall,
             id_flush, ex_flush, mem_flush, wb_flush,
             fwd_a_sel, fwd_b_sel, trap_take, bus_timeout};
      n_checks++;
      if (got !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got %b expected %b", e.name, got, e.exp);
      end
    end
  end

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_waddr = 0; ex_we = 0; ex_mem_read = 0;
    mem_waddr = 0; mem_we = 0;
    if_busy = 0; mem_busy = 0; ex_branch_taken = 0; mem_exception = 0;
  endtask

  // Inputs are already driven (just after a rising edge); queue the expected
  // response for this cycle and advance to just after the next rising edge.
  task automatic chk(input string name, input logic [14:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", mk(S0, F_ALL, RF, RF, 0, 0));

    rst_n = 1'b1;
    chk("idle", mk(S0, F0, RF, RF, 0, 0));

    ex_mem_read = 1; ex_we = 1; ex_waddr = 5; id_rs1 = 5; id_use_rs1 = 1;
    chk("load_use_rs1", mk(S_LU, F_LU, RF, RF, 0, 0));

    idle(); mem_we = 1; mem_waddr = 5; id_rs1 = 5; id_use_rs1 = 1;
    chk("load_use_one_bubble", mk(S0, F0, MEM, RF, 0, 0));

    idle(); ex_mem_read = 1; ex_we = 1; ex_waddr = 7; id_rs2 = 7; id_use_rs2 = 1;
    chk("load_use_rs2", mk(S_LU, F_LU, RF, RF, 0, 0));

    id_use_rs2 = 0;
    chk("load_unused_src", mk(S0, F0, RF, RF, 0, 0));

    idle(); ex_mem_read = 1; ex_we = 1; ex_waddr = 0; id_rs1 = 0; id_use_rs1 = 1;
    chk("load_x0", mk(S0, F0, RF, RF, 0, 0));

    idle(); ex_mem_read = 1; ex_we = 0; ex_waddr = 5; id_rs1 = 5; id_use_rs1 = 1;
    chk("load_no_we", mk(S0, F0, RF, RF, 0, 0));

    idle(); ex_we = 1; ex_waddr = 3; mem_we = 1; mem_waddr = 3; id_rs2 = 3;
    chk("fwd_b_ex", mk(S0, F0, RF, EX, 0, 0));

    ex_waddr = 0;
    chk("fwd_b_mem", mk(S0, F0, RF, MEM, 0, 0));

    idle(); ex_we = 1; ex_waddr = 6; mem_we = 1; mem_waddr = 9; id_rs1 = 9; id_rs2 = 6;
    chk("fwd_mix", mk(S0, F0, MEM, EX, 0, 0));

    idle(); ex_we = 1; mem_we = 1;
    chk("fwd_x0", mk(S0, F0, RF, RF, 0, 0));

    idle(); ex_branch_taken = 1;
    chk("branch", mk(S0, F_BR, RF, RF, 0, 0));

    ex_mem_read = 1; ex_we = 1; ex_waddr = 5; id_rs1 = 5; id_use_rs1 = 1;
    chk("branch_with_load_use", mk(S_LU, F_LU, RF, RF, 0, 0));

    idle(); if_busy = 1;
    chk("if_busy", mk(S_PC, F_ID, RF, RF, 0, 0));

    ex_branch_taken = 1;
    chk("branch_over_if_busy", mk(S0, F_BR, RF, RF, 0, 0));

    idle();
    chk("idle_after_if_busy", mk(S0, F0, RF, RF, 0, 0));

    mem_exception = 1; mem_busy = 1;
    chk("trap_vs_mem_busy", mk(S0, F_ALL, RF, RF, 0, 0));

    chk("trap_drain", mk(S0, F_DR, RF, RF, 1, 0));

    mem_exception = 0;
    chk("trap_back_to_run", mk(S_MB, F_WB, RF, RF, 0, 0));

    for (int k = 0; k < 3; k++) chk("trap_clears_count", mk(S_MB, F_WB, RF, RF, 0, 0));
    idle();
    chk("timeout_after_trap", mk(S0, F0, RF, RF, 0, 1));
    chk("timeout_cleared", mk(S0, F0, RF, RF, 0, 0));

    for (int k = 1; k <= 10; k++) begin
      mem_busy = 1;
      chk("timeout_long_stall", mk(S_MB, F_WB, RF, RF, 0, (k == 5)));
    end
    idle();
    chk("timeout_release", mk(S0, F0, RF, RF, 0, 0));

    for (int k = 1; k <= 5; k++) begin
      mem_busy = (k <= 4);
      if (k <= 4) chk("timeout_restart", mk(S_MB, F_WB, RF, RF, 0, 0));
      else        chk("timeout_restart_pulse", mk(S0, F0, RF, RF, 0, 1));
    end

    idle(); if_busy = 1;
    chk("pre_trap_if_busy", mk(S_PC, F_ID, RF, RF, 0, 0));
    chk("pre_trap_if_busy", mk(S_PC, F_ID, RF, RF, 0, 0));
    mem_exception = 1;
    chk("trap2", mk(S0, F_ALL, RF, RF, 0, 0));

    idle(); rst_n = 1'b0;
    chk("reset_in_drain", mk(S0, F_ALL, RF, RF, 0, 0));
    chk("reset_hold", mk(S0, F_ALL, RF, RF, 0, 0));

    rst_n = 1'b1; mem_busy = 1;
    for (int k = 0; k < 4; k++) chk("reset_clears_count", mk(S_MB, F_WB, RF, RF, 0, 0));
    idle();
    chk("reset_count_pulse", mk(S0, F0, RF, RF, 0, 1));
    chk("final_idle", mk(S0, F0, RF, RF, 0, 0));

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
